// File: rtl/mersenne_pkg.sv
// Shared constants, types and helpers for the pipelined Mersenne-field multiplier.
package mersenne_pkg;

    localparam int unsigned MMUL_LATENCY = 3;
    localparam int unsigned MMUL_WIDTH   = 31;

    // Per-lane S2 sum and S1 product types at the default field width
    typedef logic [MMUL_WIDTH:0]        mmul_sum_t;
    typedef logic [2*MMUL_WIDTH-1:0]    mmul_prod_t;

    function automatic logic [63:0] mersenne_p(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/mersenne_mul_lane.sv
// One lane of the Mersenne multiplier: product, fold, and canonicalising fold.
module mersenne_mul_lane
    import mersenne_pkg::*;
#(
    parameter int unsigned WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en1,
    input  logic             i_en2,
    input  logic             i_en3,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r
);

    localparam int unsigned    PW = 2 * WIDTH;
    localparam int unsigned    SW = WIDTH + 1;
    localparam logic [WIDTH-1:0] P = WIDTH'(mersenne_p(WIDTH));

    logic [PW-1:0]    r_x;
    logic [SW-1:0]    r_s;
    logic [WIDTH-1:0] r_r;
    logic [SW-1:0]    w_s;
    logic [WIDTH-1:0] w_t;

    // 2^WIDTH == 1 mod p, so the high half folds onto the low half
    always_comb begin
        w_s = SW'(r_x[WIDTH-1:0]) + SW'(r_x[PW-1:WIDTH]);
        w_t = r_s[WIDTH-1:0] + WIDTH'(r_s[WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_s <= '0;
            r_r <= '0;
        end else begin
            if (i_en1) r_x <= PW'(i_a) * PW'(i_b);
            if (i_en2) r_s <= w_s;
            if (i_en3) r_r <= (w_t == P) ? '0 : w_t;
        end
    end

    assign o_r = r_r;

endmodule

// File: rtl/mersenne_mul_pipe.sv
// LANES-wide pipelined multiplier mod 2^WIDTH-1 with valid/ready handshake and tag.
// Optional perf counters (ops_count, stall_count) enabled by MERSENNE_MUL_PERF_EN.
module mersenne_mul_pipe
    import mersenne_pkg::*;
#(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned LANES = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_r,
    output logic [TAG_W-1:0]       out_tag
`ifdef MERSENNE_MUL_PERF_EN
    ,
    output logic [31:0]            ops_count,
    output logic [31:0]            stall_count
`endif
);

    logic [MMUL_LATENCY-1:0] r_valid;
    logic [TAG_W-1:0]        r_tag1;
    logic [TAG_W-1:0]        r_tag2;
    logic [TAG_W-1:0]        r_tag3;

    logic w_adv1;
    logic w_adv2;
    logic w_adv3;
    logic w_acc2;
    logic w_acc3;
    logic w_in_ready;
    logic w_en1;

    // Ready ripples back from the consumer so bubbles are squeezed out
    always_comb begin
        w_adv3     = r_valid[2] && out_ready;
        w_acc3     = !r_valid[2] || w_adv3;
        w_adv2     = r_valid[1] && w_acc3;
        w_acc2     = !r_valid[1] || w_adv2;
        w_adv1     = r_valid[0] && w_acc2;
        w_in_ready = !r_valid[0] || w_adv1;
        w_en1      = in_valid && w_in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            r_tag3  <= '0;
        end else begin
            if (w_in_ready) r_valid[0] <= in_valid;
            if (w_acc2)     r_valid[1] <= r_valid[0];
            if (w_acc3)     r_valid[2] <= r_valid[1];
            if (w_en1)      r_tag1     <= in_tag;
            if (w_adv1)     r_tag2     <= r_tag1;
            if (w_adv2)     r_tag3     <= r_tag2;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mersenne_mul_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en1 (w_en1),
            .i_en2 (w_adv1),
            .i_en3 (w_adv2),
            .i_a   (in_a[g*WIDTH +: WIDTH]),
            .i_b   (in_b[g*WIDTH +: WIDTH]),
            .o_r   (out_r[g*WIDTH +: WIDTH])
        );
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid[2];
    assign out_tag   = r_tag3;

`ifdef MERSENNE_MUL_PERF_EN
    // Free-running wrap-around counters of completed and stalled output cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_adv3)                    ops_count   <= ops_count + 32'd1;
            if (r_valid[2] && !out_ready)  stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mersenne_mul_pipe.sv
// Self-checking bench for mersenne_mul_pipe (WIDTH=31, LANES=4): directed vectors,
// a queue-based reference model, back-pressure, and mid-flight reset.
module tb_mersenne_mul_pipe;

    localparam int unsigned    W  = 31;
    localparam int unsigned    L  = 4;
    localparam int unsigned    TW = 4;
    localparam int unsigned    DW = L * W;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a      = '0;
    logic [DW-1:0] in_b      = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_r;
    logic [TW-1:0] out_tag;
`ifdef MERSENNE_MUL_PERF_EN
    logic [31:0]   ops_count;
    logic [31:0]   stall_count;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    logic bp_en  = 1'b0;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          q[$];
    logic          stalled  = 1'b0;
    logic [DW-1:0] prev_r   = '0;
    logic [TW-1:0] prev_tag = '0;

    always #5 clk = ~clk;

    mersenne_mul_pipe #(
        .WIDTH (W),
        .LANES (L),
        .TAG_W (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_tag     (out_tag)
`ifdef MERSENNE_MUL_PERF_EN
        ,
        .ops_count   (ops_count),
        .stall_count (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic per lane
    function automatic logic [DW-1:0] model_r(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            longint unsigned x;
            x = 64'(a[i*W +: W]) * 64'(b[i*W +: W]);
            r[i*W +: W] = W'(x % P);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_operand();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 15))
                0:       v[i*W +: W] = W'(P);
                1:       v[i*W +: W] = W'(P - 1);
                2:       v[i*W +: W] = '0;
                default: v[i*W +: W] = W'($urandom());
            endcase
        end
        return v;
    endfunction

    // Compare process: handshakes are evaluated just before the edge that commits them
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            chk("in_ready_vs_occupancy", 128'(in_ready), 128'(!(q.size() == 3 && !out_ready)));
            if (q.size() == 0)
                chk("idle_out_valid", 128'(out_valid), 128'(0));
            if (stalled) begin
                chk("stall_hold_valid", 128'({out_valid, out_tag}), 128'({1'b1, prev_tag}));
                chk("stall_hold_r", 128'(out_r), 128'(prev_r));
            end
            if (out_valid && out_ready) begin
                chk("out_has_expected", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) begin
                    chk("out_r", 128'(out_r), 128'(q[0].r));
                    chk("out_tag", 128'(out_tag), 128'(q[0].tag));
                    void'(q.pop_front());
                end
                n_out++;
            end
            stalled  = out_valid && !out_ready;
            prev_r   = out_r;
            prev_tag = out_tag;
            if (in_valid && in_ready)
                q.push_back('{r: model_r(in_a, in_b), tag: in_tag});
        end
    end

    // Random consumer back-pressure, active only while bp_en is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 9) < 4);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
        bit acc;
        int budget;
        acc    = 1'b0;
        budget = 200;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) chk("send_accept_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("drain_queue_empty", 128'(q.size()), 128'(0));
    endtask

    logic [DW-1:0] a1, b1, e1, a2, b2, e2;
    int            n0;
    longint        t0;

    initial begin
        a1 = {31'h7FFF_FFFF, 31'h4000_0000, 31'h7FFF_FFFE, 31'd686829796};
        b1 = {31'd12345,     31'd2,         31'h7FFF_FFFE, 31'd742061112};
        e1 = {31'd0,         31'd1,         31'd1,         31'd888237472};
        a2 = {31'd2, 31'd1, 31'h7FFF_FFFF, 31'd0};
        b2 = {31'd3, 31'd1, 31'h7FFF_FFFF, 31'h7FFF_FFFE};
        e2 = {31'd6, 31'd1, 31'd0,         31'd0};

        chk("model_pin_beat1", 128'(model_r(a1, b1)), 128'(e1));
        chk("model_pin_beat2", 128'(model_r(a2, b2)), 128'(e2));

        #1;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_r", 128'(out_r), 128'(0));
        chk("reset_out_tag", 128'(out_tag), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));

        // Latency: the accepting edge loads S1, result visible after two more edges
        send(a1, b1, 4'd5);
        chk("lat_valid_edge1", 128'(out_valid), 128'(0));
        send(a2, b2, 4'd9);
        chk("lat_valid_edge2", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        chk("lat_valid_edge3", 128'(out_valid), 128'(1));
        chk("directed_r1", 128'(out_r), 128'(e1));
        chk("directed_tag1", 128'(out_tag), 128'(5));
        @(posedge clk);
        #1;
        chk("directed_valid2", 128'(out_valid), 128'(1));
        chk("directed_r2", 128'(out_r), 128'(e2));
        chk("directed_tag2", 128'(out_tag), 128'(9));
        drain();

        // Full-rate stream with the consumer always ready
        n0 = n_out;
        t0 = $time;
        for (int i = 0; i < 64; i++)
            send(rnd_operand(), rnd_operand(), TW'(i));
        chk("stream_cycles", 128'(($time - t0) / 10), 128'(64));
        repeat (3) @(posedge clk);
        #1;
        chk("stream_results", 128'(n_out - n0), 128'(64));
        drain();

        // Random back-pressure with a continuous producer
        n0 = n_out;
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++)
            send(rnd_operand(), rnd_operand(), TW'(i + 3));
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        drain();
        chk("bp_results", 128'(n_out - n0), 128'(40));

        // Reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(rnd_operand(), rnd_operand(), TW'(i + 1));
        @(posedge clk);
        #1;
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_out_valid", 128'(out_valid), 128'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 128'(out_valid), 128'(0));
        chk("async_reset_r", 128'(out_r), 128'(0));
        chk("async_reset_tag", 128'(out_tag), 128'(0));
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midreset", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_beat", 128'(out_valid), 128'(0));

`ifdef MERSENNE_MUL_PERF_EN
        chk("ops_after_reset", 128'(ops_count), 128'(0));
        chk("stall_after_reset", 128'(stall_count), 128'(0));
        out_ready = 1'b0;
        send(a1, b1, 4'd1);
        begin
            int budget;
            budget = 20;
            while (!out_valid && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
        end
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++)
            send(rnd_operand(), rnd_operand(), TW'(i));
        drain();
        chk("perf_ops", 128'(ops_count), 128'(10));
        chk("perf_stall", 128'(stall_count), 128'(7));
        force dut.ops_count = 32'hFFFF_FFFF;
        #1;
        release dut.ops_count;
        send(a2, b2, 4'd2);
        drain();
        chk("perf_ops_wrap", 128'(ops_count), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
